pipe_pal_ingress: RTL and testbench

Upstream buffering stage that feeds the pipe_pal datapath stage. It accepts W_DATA-bit words on a valid/ready slave interface and stores them in a small first-word-fall-through FIFO. It presents the words in order on a valid/ready master interface. It also reports FIFO occupancy and keeps a running count of words delivered downstream.

---
 rtl/pipe_pal_ingress.sv | 86 ++++++++
 tb/tb_pipe_pal_ingress.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_pal_ingress.sv
// Ingress buffer for pipe_pal: first-word-fall-through FIFO between valid/ready
// interfaces, with an occupancy output and a count of words delivered downstream.
module pipe_pal_ingress #(
   parameter int W_DATA = 32,
   parameter int DEPTH  = 4,
   parameter int W_CNT  = 16
) (
   input  logic                     i_clk,
   input  logic                     reset,
   input  logic                     i_flush,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [W_DATA-1:0]        s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [W_DATA-1:0]        m_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [W_CNT-1:0]         o_words
);

   localparam int W_PTR = $clog2(DEPTH);
   localparam int W_LVL = W_PTR + 1;
   localparam logic [W_LVL-1:0] LVL_FULL = W_LVL'(DEPTH);

   logic [W_DATA-1:0] mem [DEPTH];
   logic [W_PTR-1:0]  wr_ptr;
   logic [W_PTR-1:0]  rd_ptr;
   logic [W_LVL-1:0]  level;
   logic [W_LVL-1:0]  level_nxt;
   logic [W_CNT-1:0]  words;
   logic              push;
   logic              pop;

   // Handshakes come from registered level only, so m_ready never reaches s_ready.
   assign s_ready = !reset && (level != LVL_FULL);
   assign m_valid = !reset && (level != '0);
   assign m_data  = mem[rd_ptr];

   // Flush suppresses both transfers; reset is already folded into the readies.
   assign push = s_valid && s_ready && !i_flush;
   assign pop  = m_valid && m_ready && !i_flush;

   assign o_level = level;
   assign o_words = words;

   always_comb begin
      // NOTE: default first so every path assigns level_nxt and no latch is inferred.
      level_nxt = level;
      case ({push, pop})
         2'b10:   level_nxt = level + W_LVL'(1);
         2'b01:   level_nxt = level - W_LVL'(1);
         default: level_nxt = level;
      endcase
   end

   // NOTE: storage is deliberately not reset; level alone says which entries are live.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (reset) begin
         level  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         words  <= '0;
      end else if (i_flush) begin
         level  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         level <= level_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + W_PTR'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + W_PTR'(1);
            words  <= words + W_CNT'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_pal_ingress.sv
// Directed bench for pipe_pal_ingress: a queue of hand-computed expected words is
// filled by the stimulus and drained by a monitor on every downstream transfer.
module tb_pipe_pal_ingress;

   localparam int W_DATA = 32;
   localparam int DEPTH  = 4;
   localparam int W_CNT  = 4;

   logic              i_clk = 1'b0;
   logic              reset;
   logic              i_flush;
   logic              s_valid;
   logic              s_ready;
   logic [W_DATA-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [W_DATA-1:0] m_data;
   logic [2:0]        o_level;
   logic [W_CNT-1:0]  o_words;

   int n_vec = 0;
   int n_err = 0;
   logic [W_DATA-1:0] exp_q [$];

   pipe_pal_ingress #(.W_DATA(W_DATA), .DEPTH(DEPTH), .W_CNT(W_CNT)) dut (
      .i_clk   (i_clk),
      .reset   (reset),
      .i_flush (i_flush),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .o_level (o_level),
      .o_words (o_words)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Monitor: inputs are stable at the falling edge, so a transfer here will
   // happen at the next rising edge.
   always @(negedge i_clk) begin
      if (m_valid === 1'b1 && m_ready === 1'b1 && i_flush === 1'b0) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pop: got 0x%0h, expected no transfer at %0t", m_data, $time);
         end else begin
            check("m_data", m_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset   = 1'b1;
      i_flush = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'hdead;
      m_ready = 1'b1;

      // 1: reset held three cycles with handshakes asserted
      repeat (3) begin
         tick();
         check("rst_s_ready", {31'd0, s_ready}, 32'd0);
         check("rst_m_valid", {31'd0, m_valid}, 32'd0);
         check("rst_level", {29'd0, o_level}, 32'd0);
         check("rst_words", {28'd0, o_words}, 32'd0);
      end
      reset   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      #1;
      check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

      // 2: fill with m_ready low; the fifth word waits for a pop
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = 32'h11 * (i + 1);
         exp_q.push_back(32'h11 * (i + 1));
         tick();
      end
      s_data = 32'h55;
      check("full_level", {29'd0, o_level}, 32'd4);
      check("full_s_ready", {31'd0, s_ready}, 32'd0);
      check("full_head", m_data, 32'h11);
      tick();
      tick();
      check("held_level", {29'd0, o_level}, 32'd4);
      check("held_head", m_data, 32'h11);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("pop_full_level", {29'd0, o_level}, 32'd3);
      check("pop_full_s_ready", {31'd0, s_ready}, 32'd1);
      exp_q.push_back(32'h55);
      tick();
      s_valid = 1'b0;
      check("refill_level", {29'd0, o_level}, 32'd4);
      check("refill_words", {28'd0, o_words}, 32'd1);

      // 3: drain the full FIFO
      m_ready = 1'b1;
      repeat (4) tick();
      m_ready = 1'b0;
      check("drain_level", {29'd0, o_level}, 32'd0);
      check("drain_m_valid", {31'd0, m_valid}, 32'd0);
      check("drain_words", {28'd0, o_words}, 32'd5);

      // 4: streaming through the pointer wrap with one-cycle latency
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1;
         s_data  = i;
         exp_q.push_back(i);
         tick();
         check("stream_level", {29'd0, o_level}, 32'd1);
         check("stream_m_valid", {31'd0, m_valid}, 32'd1);
      end
      s_valid = 1'b0;
      tick();
      m_ready = 1'b0;
      check("stream_end_level", {29'd0, o_level}, 32'd0);
      check("stream_words", {28'd0, o_words}, 32'd15);

      // 5: flush at level 2 with both handshakes asserted
      s_valid = 1'b1;
      s_data  = 32'ha0;
      tick();
      s_data  = 32'ha1;
      tick();
      check("preflush_level", {29'd0, o_level}, 32'd2);
      s_data  = 32'hbb;
      m_ready = 1'b1;
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      check("flush_level", {29'd0, o_level}, 32'd0);
      check("flush_m_valid", {31'd0, m_valid}, 32'd0);
      check("flush_words", {28'd0, o_words}, 32'd15);
      s_valid = 1'b1;
      s_data  = 32'hc0;
      exp_q.push_back(32'hc0);
      tick();
      s_valid = 1'b0;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("wrap_words", {28'd0, o_words}, 32'd0);

      // 6: 17 pops from a clean reset wraps a 4-bit counter to 1
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2_words", {28'd0, o_words}, 32'd0);
      m_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         s_valid = 1'b1;
         s_data  = 32'h100 + i;
         exp_q.push_back(32'h100 + i);
         tick();
      end
      s_valid = 1'b0;
      tick();
      m_ready = 1'b0;
      check("cnt_wrap_words", {28'd0, o_words}, 32'd1);
      check("cnt_wrap_level", {29'd0, o_level}, 32'd0);

      tick();
      check("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
